// File: rtl/bram_fifo_source.sv
// Host-loaded word store drained by a first-word-fall-through consumer port,
// with optional looping playback, a transfer limit and a byte-wide register bus.
module bram_fifo_source #(
    parameter int unsigned DEPTH     = 32'h2000,
    parameter int unsigned ABUSWIDTH = 32
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST_N,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    input  logic [7:0]           BUS_DATA_IN,
    input  logic                 BUS_RD,
    input  logic                 BUS_WR,
    output logic [7:0]           BUS_DATA_OUT,
    input  logic                 BUS_WR_DATA,
    input  logic [31:0]          BUS_DATA_IN_DATA,
    input  logic                 FIFO_READ,
    output logic                 FIFO_EMPTY,
    output logic [31:0]          FIFO_DATA,
    output logic                 BUSY,
    output logic                 OVERFLOW
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t         state, state_n;

    logic [31:0]    mem [DEPTH];
    logic [31:0]    ram_q;

    logic [AW-1:0]  wr_ptr, rd_ptr, base_ptr;
    logic [AW-1:0]  rd_n, base_n, rd_inc;
    logic [FW-1:0]  fill, fill_c;
    logic [15:0]    sent, sent_n, sent_inc;
    logic [15:0]    size_reg, size_lat, size_n;
    logic           loop_reg, loop_lat, loop_n;
    logic [7:0]     ovf_cnt, udr_cnt;
    logic [7:0]     sent_hi_buf, fill_hi_buf;
    logic           out_valid, valid_n;

    logic           addr_ok;
    logic [3:0]     sel;
    logic           soft_rst, ctrl_wr, start_cmd, stop_cmd;
    logic           full, wr_ok, wr_drop, hs, underrun;
    logic [31:0]    fill32;
    logic [15:0]    fill16;
    logic [7:0]     status, rd_mux;

    // Register-bus decode and store-side strobes
    always_comb begin
        addr_ok   = (BUS_ADD >> 4) == '0;
        sel       = BUS_ADD[3:0];
        soft_rst  = BUS_WR && addr_ok && (sel == 4'd0);
        ctrl_wr   = BUS_WR && addr_ok && (sel == 4'd1);
        // STOP wins over a simultaneous START
        start_cmd = ctrl_wr && BUS_DATA_IN[0] && !BUS_DATA_IN[2];
        stop_cmd  = ctrl_wr && BUS_DATA_IN[2];
        full      = fill == FW'(DEPTH);
        wr_ok     = BUS_WR_DATA && !full;
        wr_drop   = BUS_WR_DATA && full;
        // a restart or stop never consumes the presented word
        hs        = FIFO_READ && out_valid && !start_cmd && !stop_cmd;
        underrun  = FIFO_READ && !out_valid;
        fill32    = 32'(fill);
        fill16    = fill32[15:0];
        status    = {4'b0, (fill == '0), full, (state == ST_DONE), (state == ST_STREAM)};
    end

    // Next state, read/base pointers and prefetch validity
    always_comb begin
        state_n  = state;
        rd_n     = rd_ptr;
        base_n   = base_ptr;
        fill_c   = fill;
        sent_n   = sent;
        size_n   = size_lat;
        loop_n   = loop_lat;
        rd_inc   = rd_ptr + 1'b1;
        sent_inc = sent + 16'd1;
        if (start_cmd) begin
            state_n = ST_STREAM;
            sent_n  = '0;
            size_n  = size_reg;
            loop_n  = BUS_DATA_IN[1];
            rd_n    = base_ptr;
        end else if (stop_cmd && state == ST_STREAM) begin
            state_n = ST_IDLE;
        end else if (hs) begin
            sent_n = sent_inc;
            if (loop_lat) begin
                rd_n = (rd_inc == wr_ptr) ? base_ptr : rd_inc;
            end else begin
                rd_n   = rd_inc;
                base_n = base_ptr + 1'b1;
                fill_c = fill - 1'b1;
            end
            if (size_lat != '0 && sent_inc == size_lat) begin
                state_n = ST_DONE;
            end
        end
        // fill_c excludes this cycle's host write, so a fresh word is
        // presented one edge after it lands in the store
        valid_n = (state_n == ST_STREAM) && (fill_c != '0) &&
                  !(size_n != '0 && sent_n == size_n);
    end

    // Register read multiplexer
    always_comb begin
        rd_mux = '0;
        if (addr_ok) begin
            case (sel)
                4'd0:    rd_mux = 8'h01;
                4'd1:    rd_mux = {6'b0, loop_reg, 1'b0};
                4'd2:    rd_mux = size_reg[7:0];
                4'd3:    rd_mux = size_reg[15:8];
                4'd4:    rd_mux = status;
                4'd5:    rd_mux = ovf_cnt;
                4'd6:    rd_mux = sent[7:0];
                4'd7:    rd_mux = sent_hi_buf;
                4'd8:    rd_mux = fill16[7:0];
                4'd9:    rd_mux = fill_hi_buf;
                4'd10:   rd_mux = udr_cnt;
                default: rd_mux = '0;
            endcase
        end
    end

    // Word store: synchronous write, registered prefetch read
    always_ff @(posedge BUS_CLK) begin
        if (wr_ok) begin
            mem[wr_ptr] <= BUS_DATA_IN_DATA;
        end
        ram_q <= mem[rd_n];
    end

    // FSM state register
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state <= ST_IDLE;
        end else if (soft_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath, counters and register file
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            base_ptr     <= '0;
            fill         <= '0;
            sent         <= '0;
            size_reg     <= '0;
            size_lat     <= '0;
            loop_reg     <= 1'b0;
            loop_lat     <= 1'b0;
            ovf_cnt      <= '0;
            udr_cnt      <= '0;
            sent_hi_buf  <= '0;
            fill_hi_buf  <= '0;
            out_valid    <= 1'b0;
            BUS_DATA_OUT <= '0;
        end else if (soft_rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            base_ptr     <= '0;
            fill         <= '0;
            sent         <= '0;
            size_reg     <= '0;
            size_lat     <= '0;
            loop_reg     <= 1'b0;
            loop_lat     <= 1'b0;
            ovf_cnt      <= '0;
            udr_cnt      <= '0;
            sent_hi_buf  <= '0;
            fill_hi_buf  <= '0;
            out_valid    <= 1'b0;
            BUS_DATA_OUT <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr    <= rd_n;
            base_ptr  <= base_n;
            fill      <= fill_c + FW'(wr_ok);
            sent      <= sent_n;
            size_lat  <= size_n;
            loop_lat  <= loop_n;
            out_valid <= valid_n;
            if (wr_drop && ovf_cnt != 8'hFF) begin
                ovf_cnt <= ovf_cnt + 8'd1;
            end
            if (underrun && udr_cnt != 8'hFF) begin
                udr_cnt <= udr_cnt + 8'd1;
            end
            if (ctrl_wr) begin
                loop_reg <= BUS_DATA_IN[1];
            end
            if (BUS_WR && addr_ok && sel == 4'd2) begin
                size_reg[7:0] <= BUS_DATA_IN;
            end
            if (BUS_WR && addr_ok && sel == 4'd3) begin
                size_reg[15:8] <= BUS_DATA_IN;
            end
            if (BUS_RD) begin
                BUS_DATA_OUT <= rd_mux;
                if (addr_ok && sel == 4'd6) begin
                    sent_hi_buf <= sent[15:8];
                end
                if (addr_ok && sel == 4'd8) begin
                    fill_hi_buf <= fill16[15:8];
                end
            end
        end
    end

    // Consumer-facing outputs
    always_comb begin
        FIFO_EMPTY = !out_valid;
        FIFO_DATA  = out_valid ? ram_q : '0;
        BUSY       = state == ST_STREAM;
        OVERFLOW   = ovf_cnt != '0;
    end

endmodule

// File: doc/bram_fifo_source.md
BRAM_FIFO_SOURCE -- requirements
Module: bram_fifo_source

Interface
REQ-001 SHALL have parameter DEPTH, default 32'h2000, store depth in 32-bit words (power of two, >=4).
REQ-002 SHALL have parameter ABUSWIDTH, default 32, register address width.
REQ-003 SHALL have port BUS_CLK  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port BUS_RST_N  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports BUS_ADD in ABUSWIDTH, BUS_DATA_IN in 8, BUS_RD in 1, BUS_WR in 1, BUS_DATA_OUT out 8 (registered): the register bus.
REQ-006 SHALL have ports BUS_WR_DATA in 1 and BUS_DATA_IN_DATA in 32: the host word-write strobe and data.
REQ-007 SHALL have ports FIFO_READ in 1 (consumer pop), FIFO_EMPTY out 1, FIFO_DATA out 32 (first-word-fall-through).
REQ-008 SHALL have ports BUSY out 1 (state STREAM) and OVERFLOW out 1 (overflow count nonzero).

Function
REQ-009 Register map, SHALL be: 0 W soft reset / R VERSION=1; 1 CONTROL: bit0 START strobe, bit1 LOOP, bit2 STOP strobe, reads {6'b0,LOOP,0}; 2/3 SIZE[7:0]/[15:8] R/W; 4 R STATUS {4'b0,store_empty,store_full,DONE,BUSY}; 5 R OVERFLOW_CNT; 6/7 R SENT[7:0]/[15:8]; 8/9 R FILL[7:0]/[15:8]; 10 R UNDERRUN_CNT; other addresses read 0.
REQ-010 A read of 6 SHALL capture SENT[15:8] into a buffer returned by a later read of 7; likewise a read of 8 captures FILL[15:8] for 9.
REQ-011 BUS_DATA_OUT SHALL update on the edge where BUS_RD is high, holding otherwise.
REQ-012 Store SHALL be a DEPTH x 32 circular RAM with write pointer, read pointer, base pointer and FILL count, wrapping modulo DEPTH.
REQ-013 BUS_WR_DATA with FILL<DEPTH SHALL write BUS_DATA_IN_DATA at the write pointer and increment FILL; with FILL==DEPTH the word SHALL be dropped and OVERFLOW_CNT increment, saturating at 8'hFF.
REQ-014 Full SHALL be evaluated before a same-cycle consume: a write at FILL==DEPTH is dropped even if a pop occurs that cycle.
REQ-015 Writes SHALL be accepted in every state.
REQ-016 FSM states SHALL be IDLE, STREAM, DONE; START from any state -> STREAM, clears SENT, latches LOOP and SIZE, resets read pointer to base pointer.
REQ-017 STOP in STREAM -> IDLE; STOP in IDLE/DONE ignored; START and STOP together: STOP wins.
REQ-018 STREAM -> DONE on the handshake that makes SENT equal latched SIZE when SIZE!=0; SIZE==0 means unlimited.
REQ-019 Handshake = FIFO_READ && !FIFO_EMPTY; it SHALL increment SENT (wrapping 16-bit) and advance the read pointer.
REQ-020 Without LOOP a handshake SHALL also advance the base pointer and decrement FILL (word freed); with LOOP FILL is unchanged and the read pointer returns to base pointer after the newest word.
REQ-021 FIFO_EMPTY SHALL be 0 only in STREAM with an unsent word available and limit not reached; FIFO_DATA SHALL be the word at the read pointer whenever FIFO_EMPTY=0.
REQ-022 A word written on edge k into an empty store during STREAM SHALL deassert FIFO_EMPTY after edge k+1; back-to-back handshakes SHALL sustain one word per cycle.
REQ-023 Leaving STREAM SHALL assert FIFO_EMPTY on the same edge without consuming the presented word.
REQ-024 FIFO_READ while FIFO_EMPTY=1 SHALL be ignored and increment UNDERRUN_CNT, saturating at 8'hFF.

Reset
REQ-025 BUS_RST_N low SHALL immediately set IDLE, clear pointers, FILL, SENT, SIZE, LOOP, counters, FIFO_EMPTY=1, FIFO_DATA=0, BUS_DATA_OUT=0, BUSY=0, OVERFLOW=0.
REQ-026 Soft reset (BUS_WR to address 0) SHALL synchronously apply the same values on that edge; RAM contents need not be cleared.
REQ-027 Reset mid-stream SHALL discard the store; the consumer sees FIFO_EMPTY=1 with no further handshake.

Verification
REQ-028 Write 4 words A..D, SIZE=0, START, FIFO_READ held 1 -> A,B,C,D on consecutive cycles, then FIFO_EMPTY=1, FILL=0, SENT=4.
REQ-029 SIZE=3, 5 words, START, drain -> 3 words out, STATUS=8'h02 (DONE), FILL=2, FIFO_EMPTY stays 1.
REQ-030 LOOP=1, SIZE=7, words X,Y,Z, START -> X,Y,Z,X,Y,Z,X then DONE; FILL=3.
REQ-031 Write DEPTH+2 words without START -> OVERFLOW_CNT=2, OVERFLOW=1, store_full=1; 300 extra writes -> OVERFLOW_CNT=8'hFF.
REQ-032 STOP with word W presented, then START -> W reappears first; FIFO_READ with FIFO_EMPTY=1 three times -> UNDERRUN_CNT=3.
REQ-033 Assert BUS_RST_N low mid-burst asynchronously -> FIFO_EMPTY=1 and BUSY=0 before next edge; FILL reads 0 after release.
